// File: rtl/hrm_control_unit_pkg.sv
// HRM CPU control unit: opcodes, ALU/R-select codes, states, decode bundle.
// Optional build macro HRM_ILLEGAL_TRAP_EN adds the TRAP state path.
package hrm_control_unit_pkg;

  localparam logic [3:0] OP_INBOX    = 4'h0;
  localparam logic [3:0] OP_OUTBOX   = 4'h1;
  localparam logic [3:0] OP_COPYFROM = 4'h2;
  localparam logic [3:0] OP_COPYTO   = 4'h3;
  localparam logic [3:0] OP_ADD      = 4'h4;
  localparam logic [3:0] OP_SUB      = 4'h5;
  localparam logic [3:0] OP_BUMPUP   = 4'h6;
  localparam logic [3:0] OP_BUMPDN   = 4'h7;
  localparam logic [3:0] OP_JUMP     = 4'h8;
  localparam logic [3:0] OP_JUMPZ    = 4'h9;
  localparam logic [3:0] OP_JUMPN    = 4'hA;
  localparam logic [3:0] OP_HALT     = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_INC = 3'b010;
  localparam logic [2:0] ALU_DEC = 3'b011;
  localparam logic [2:0] FLAG_Z  = 3'b000;
  localparam logic [2:0] FLAG_N  = 3'b100;

  localparam logic [1:0] RSEL_ALU = 2'd0;
  localparam logic [1:0] RSEL_MEM = 2'd1;
  localparam logic [1:0] RSEL_IN  = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH,
    S_OPERAND,
    S_INDIR,
    S_EXEC,
    S_WB,
    S_WAIT_IN,
    S_WAIT_OUT,
    S_HALT,
    S_TRAP
  } state_t;

  typedef struct packed {
    logic       is_inbox;
    logic       is_outbox;
    logic       is_halt;
    logic       has_operand;
    logic       is_mem;
    logic       is_jump;
    logic       is_alu;
    logic       is_bump;
    logic       illegal;
    logic [2:0] alu_ctl;
  } dec_t;

endpackage

// File: rtl/hrm_control_unit_if.sv
// HRM control unit bus: program ROM, data RAM, R/ALU control and I/O queues.
// master = control unit side, slave = datapath / memories side.
interface hrm_control_unit_if #(
  parameter int PC_W   = 8,
  parameter int ADDR_W = 5
);
  logic [7:0]        pmem_data;
  logic [PC_W-1:0]   pc;
  logic [7:0]        mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [2:0]        alu_ctl;
  logic              alu_flag;
  logic              r_ld;
  logic [1:0]        r_sel;
  logic              inbox_valid;
  logic              inbox_rd;
  logic              outbox_ready;
  logic              outbox_wr;
  logic              halted;
  logic              illegal;

  modport master (
    input  pmem_data, mem_rdata, alu_flag,
    input  inbox_valid, outbox_ready,
    output pc, mem_addr, mem_wr, alu_ctl,
    output r_ld, r_sel, inbox_rd, outbox_wr,
    output halted, illegal
  );

  modport slave (
    output pmem_data, mem_rdata, alu_flag,
    output inbox_valid, outbox_ready,
    input  pc, mem_addr, mem_wr, alu_ctl,
    input  r_ld, r_sel, inbox_rd, outbox_wr,
    input  halted, illegal
  );
endinterface

// File: rtl/hrm_control_unit_decode.sv
// HRM opcode decoder: 4-bit op field to instruction class flags and ALU code.
module hrm_control_unit_decode
  import hrm_control_unit_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    unique case (op)
      OP_INBOX:  dec.is_inbox  = 1'b1;
      OP_OUTBOX: dec.is_outbox = 1'b1;
      OP_HALT:   dec.is_halt   = 1'b1;
      OP_COPYFROM, OP_COPYTO: begin
        dec.has_operand = 1'b1;
        dec.is_mem      = 1'b1;
      end
      OP_ADD, OP_SUB, OP_BUMPUP, OP_BUMPDN: begin
        dec.has_operand = 1'b1;
        dec.is_mem      = 1'b1;
        dec.is_alu      = 1'b1;
        dec.is_bump     = op[1];
        dec.alu_ctl     = {1'b0, op[1:0]};
      end
      OP_JUMP, OP_JUMPZ: begin
        dec.has_operand = 1'b1;
        dec.is_jump     = 1'b1;
        dec.alu_ctl     = FLAG_Z;
      end
      OP_JUMPN: begin
        dec.has_operand = 1'b1;
        dec.is_jump     = 1'b1;
        dec.alu_ctl     = FLAG_N;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/hrm_control_unit.sv
// HRM CPU instruction sequencer (FSM, pc, IR, AR, OPD).
// Build macro HRM_ILLEGAL_TRAP_EN: opcodes B-E trap instead of acting as NOPs.
module hrm_control_unit
  import hrm_control_unit_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int ADDR_W = 5
) (
  input logic               clk,
  input logic               rst,
  hrm_control_unit_if.master bus
);

`ifdef HRM_ILLEGAL_TRAP_EN
  localparam state_t ILL_NEXT = S_TRAP;
`else
  localparam state_t ILL_NEXT = S_FETCH;
`endif

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        opd_q, opd_d;
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [7:0]        dec_byte;
  dec_t              dec;
  logic              unused;

  // Decode the incoming byte while fetching, the latched IR afterwards.
  assign dec_byte = (state_q == S_FETCH) ? bus.pmem_data : ir_q;

  hrm_control_unit_decode u_dec (
    .op  (dec_byte[7:4]),
    .dec (dec)
  );

  assign bus.pc       = pc_q;
  assign bus.mem_addr = ar_q;
  assign unused = &{1'b0, dec_byte[3:0], ir_q[2:0], bus.mem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      ar_q    <= '0;
      opd_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ar_q    <= ar_d;
      opd_q   <= opd_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    ar_d          = ar_q;
    opd_d         = opd_q;
    bus.mem_wr    = 1'b0;
    bus.alu_ctl   = 3'b000;
    bus.r_ld      = 1'b0;
    bus.r_sel     = RSEL_ALU;
    bus.inbox_rd  = 1'b0;
    bus.outbox_wr = 1'b0;
    bus.halted    = 1'b0;
    bus.illegal   = 1'b0;
    // Strobes stay quiet in the reset cycle even mid-instruction.
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          ir_d = bus.pmem_data;
          pc_d = pc_q + 1'b1;
          unique case (1'b1)
            dec.is_inbox:    state_d = S_WAIT_IN;
            dec.is_outbox:   state_d = S_WAIT_OUT;
            dec.is_halt:     state_d = S_HALT;
            dec.has_operand: state_d = S_OPERAND;
            default:         state_d = ILL_NEXT;
          endcase
        end
        S_OPERAND: begin
          ar_d    = bus.pmem_data[ADDR_W-1:0];
          opd_d   = bus.pmem_data;
          pc_d    = pc_q + 1'b1;
          state_d = (dec.is_mem && ir_q[3]) ? S_INDIR : S_EXEC;
        end
        S_INDIR: begin
          ar_d    = bus.mem_rdata[ADDR_W-1:0];
          state_d = S_EXEC;
        end
        S_EXEC: begin
          bus.alu_ctl = dec.alu_ctl;
          state_d     = S_FETCH;
          unique case (1'b1)
            dec.is_alu: begin
              bus.r_ld  = 1'b1;
              bus.r_sel = RSEL_ALU;
              if (dec.is_bump) state_d = S_WB;
            end
            dec.is_jump: begin
              if (ir_q[7:4] == OP_JUMP || bus.alu_flag)
                pc_d = PC_W'(opd_q);
            end
            ir_q[7:4] == OP_COPYFROM: begin
              bus.r_ld  = 1'b1;
              bus.r_sel = RSEL_MEM;
            end
            ir_q[7:4] == OP_COPYTO: bus.mem_wr = 1'b1;
            default: ;
          endcase
        end
        S_WB: begin
          bus.mem_wr = 1'b1;
          state_d    = S_FETCH;
        end
        S_WAIT_IN: begin
          if (bus.inbox_valid) begin
            bus.inbox_rd = 1'b1;
            bus.r_ld     = 1'b1;
            bus.r_sel    = RSEL_IN;
            state_d      = S_FETCH;
          end
        end
        S_WAIT_OUT: begin
          if (bus.outbox_ready) begin
            bus.outbox_wr = 1'b1;
            state_d       = S_FETCH;
          end
        end
        S_HALT: bus.halted = 1'b1;
        S_TRAP: begin
          bus.halted = 1'b1;
`ifdef HRM_ILLEGAL_TRAP_EN
          bus.illegal = 1'b1;
`endif
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule
